// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, scan-driver command codes
// and FSM states, instruction codes, and preamble TMS tables.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        SELECT_DR        = 4'h1,
        CAPTURE_DR       = 4'h2,
        SHIFT_DR         = 4'h3,
        EXIT1_DR         = 4'h4,
        PAUSE_DR         = 4'h5,
        EXIT2_DR         = 4'h6,
        UPDATE_DR        = 4'h7,
        SELECT_IR        = 4'h8,
        CAPTURE_IR       = 4'h9,
        SHIFT_IR         = 4'ha,
        EXIT1_IR         = 4'hb,
        PAUSE_IR         = 4'hc,
        EXIT2_IR         = 4'hd,
        UPDATE_IR        = 4'he,
        RUN_TEST_IDLE    = 4'hf
    } tap_state_e;

    typedef enum logic [1:0] {
        CMD_RESET = 2'b00,
        CMD_IR    = 2'b01,
        CMD_DR    = 2'b10,
        CMD_IDLE  = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SHIFT, S_POSTAMBLE, S_DONE
    } drv_state_e;

    localparam logic [3:0] BYPASS = 4'b0000;
    localparam logic [3:0] IDCODE = 4'b1000;

    // Index of the last preamble TCK; RESET's whole sequence lives in the preamble.
    function automatic logic [2:0] pre_last(cmd_type_e t);
        case (t)
            CMD_RESET: return 3'd5;
            CMD_IR:    return 3'd3;
            CMD_DR:    return 3'd2;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic pre_tms(cmd_type_e t, logic [2:0] i);
        case (t)
            CMD_RESET: return i != 3'd5;
            CMD_IR:    return i < 3'd2;
            CMD_DR:    return i == 3'd0;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: DIV clocks low then DIV clocks high while run is held;
// rise/fall strobe on the clock cycle whose edge flips TCK.
module jtag_tck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = run && (div_cnt == CW'(DIV - 1));
    assign rise = wrap && !tck;
    assign fall = wrap && tck;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_scan_driver.sv
// Host-side JTAG master: turns RESET / IR / DR / idle-clock commands into
// TCK/TMS/TDI sequences and returns captured TDO on a one-cycle strobe.
module jtag_scan_driver
    import jtag_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_TYPE,
    input  logic [LEN_W-1:0]   CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               RSP_ERR,
    output logic               SYNCED,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);
    typedef logic [LEN_W:0] cnt_t;

    drv_state_e         state, state_n;
    cnt_t               cnt, cnt_n;
    cmd_type_e          ctype, t_sel;
    logic [LEN_W-1:0]   clen, l_sel;
    logic [MAX_LEN-1:0] cdata, d_sel, cap;
    logic               accept, run, rise, fall, finish, step;
    logic               tms_n, tdi_n, active_n;

    assign CMD_READY = (state == S_IDLE);
    assign accept    = CMD_VALID && CMD_READY;
    assign run       = state inside {S_PREAMBLE, S_SHIFT, S_POSTAMBLE};
    assign step      = accept || fall;
    assign active_n  = state_n inside {S_PREAMBLE, S_SHIFT, S_POSTAMBLE};

    // On the accept cycle the sequencer looks at the incoming command directly.
    assign t_sel = accept ? cmd_type_e'(CMD_TYPE) : ctype;
    assign l_sel = accept ? CMD_LEN : clen;
    assign d_sel = accept ? CMD_DATA : cdata;

    jtag_tck_gen #(.DIV(DIV)) u_tck (
        .clk   (CLK),
        .rst_n (RST_N),
        .run   (run),
        .tck   (TCK),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        finish  = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                cnt_n = '0;
                if (t_sel inside {CMD_IR, CMD_DR} && !SYNCED) state_n = S_DONE;
                else if (t_sel == CMD_IDLE)                    state_n = S_SHIFT;
                else                                           state_n = S_PREAMBLE;
            end
            S_PREAMBLE: if (fall) begin
                if (cnt == cnt_t'(pre_last(ctype))) begin
                    if (ctype == CMD_RESET) finish = 1'b1;
                    else begin
                        state_n = S_SHIFT;
                        cnt_n   = '0;
                    end
                end else cnt_n = cnt + 1'b1;
            end
            S_SHIFT: if (fall) begin
                if (cnt == cnt_t'(clen)) begin
                    if (ctype == CMD_IDLE) finish = 1'b1;
                    else begin
                        state_n = S_POSTAMBLE;
                        cnt_n   = '0;
                    end
                end else cnt_n = cnt + 1'b1;
            end
            S_POSTAMBLE: if (fall) begin
                if (cnt == cnt_t'(1)) finish = 1'b1;
                else                  cnt_n  = cnt + 1'b1;
            end
            S_DONE:  finish = 1'b1;
            default: state_n = S_IDLE;
        endcase
        if (finish) state_n = S_IDLE;
    end

    // TMS/TDI for the TCK that the next state/count position describes.
    always_comb begin
        tms_n = TMS;
        tdi_n = 1'b0;
        case (state_n)
            S_PREAMBLE:  tms_n = pre_tms(t_sel, cnt_n[2:0]);
            S_SHIFT: begin
                tms_n = (t_sel != CMD_IDLE) && (cnt_n == cnt_t'(l_sel));
                tdi_n = (t_sel != CMD_IDLE) && d_sel[cnt_n[LEN_W-1:0]];
            end
            S_POSTAMBLE: tms_n = (cnt_n == '0);
            default:     tms_n = TMS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ctype     <= CMD_RESET;
            clen      <= '0;
            cdata     <= '0;
            cap       <= '0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            SYNCED    <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
        end else begin
            RSP_VALID <= finish;
            if (accept) begin
                ctype <= t_sel;
                clen  <= CMD_LEN;
                cdata <= CMD_DATA;
                cap   <= '0;
            end
            if (rise && state == S_SHIFT && ctype != CMD_IDLE)
                cap[cnt[LEN_W-1:0]] <= TDO;
            if (step && active_n) begin
                TMS <= tms_n;
                TDI <= tdi_n;
            end
            if (finish) begin
                RSP_ERR  <= (state == S_DONE);
                RSP_DATA <= (ctype inside {CMD_IR, CMD_DR} && state != S_DONE) ? cap : '0;
                if (ctype == CMD_RESET) SYNCED <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_driver.sv
// Bench for jtag_scan_driver: a behavioural TAP (4-bit IR, IDCODE/BYPASS DRs)
// hangs off the pins; expected TMS/TDI streams and responses come from the scan rules.
module tb_jtag_scan_driver;
    import jtag_pkg::*;

    localparam int DIV = 2, MAX_LEN = 32, LEN_W = 5, T = 10;

    logic CLK = 1'b0, RST_N = 1'b0, CMD_VALID = 1'b0, TDO = 1'b0;
    logic [1:0]         CMD_TYPE = 2'b00;
    logic [LEN_W-1:0]   CMD_LEN  = '0;
    logic [MAX_LEN-1:0] CMD_DATA = '0;
    logic               CMD_READY, RSP_VALID, RSP_ERR, SYNCED, TCK, TMS, TDI;
    logic [MAX_LEN-1:0] RSP_DATA;

    int checks = 0, errors = 0;

    jtag_scan_driver #(.DIV(DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .SYNCED(SYNCED),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #(T/2) CLK = ~CLK;

    // ---------------- behavioural TAP ----------------
    tap_state_e  tap = TEST_LOGIC_RESET;
    logic [3:0]  ir = IDCODE;
    logic [63:0] sr = '0;
    int          sr_len = 1;
    bit          mon_tms[$], mon_tdi[$];
    time         mon_t[$];

    function automatic tap_state_e tap_nx(tap_state_e s, logic m);
        case (s)
            TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    return m ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        return m ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       return m ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         return m ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         return m ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         return m ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         return m ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        return m ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        return m ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       return m ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         return m ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         return m ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         return m ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         return m ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        return m ? SELECT_DR : RUN_TEST_IDLE;
            default:          return TEST_LOGIC_RESET;
        endcase
    endfunction

    always @(posedge TCK) begin
        mon_tms.push_back(TMS);
        mon_tdi.push_back(TDI);
        mon_t.push_back($time);
        case (tap)
            TEST_LOGIC_RESET: ir = IDCODE;
            CAPTURE_DR: begin
                sr_len = (ir == IDCODE) ? 32 : 1;
                sr     = (ir == IDCODE) ? 64'hF0F0F0F0 : 64'h0;
            end
            CAPTURE_IR: begin
                sr_len = 4;
                sr     = 64'h1;
            end
            SHIFT_DR, SHIFT_IR: begin
                sr = sr >> 1;
                sr[sr_len-1] = TDI;
            end
            UPDATE_IR: ir = sr[3:0];
            default: ;
        endcase
        tap = tap_nx(tap, TMS);
    end

    always @(negedge TCK)
        TDO = (tap == SHIFT_DR || tap == SHIFT_IR) ? sr[0] : 1'b0;

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) if (i < 64) v[i] = q[i];
        return v;
    endfunction

    bit          exp_tms[$], exp_tdi[$];
    logic [3:0]  exp_ir = IDCODE;

    // Drive one command, wait for its response; lat = cycles from accept edge.
    task automatic do_cmd(input logic [1:0] t, input logic [LEN_W-1:0] l, input logic [31:0] d,
                          output logic [31:0] rd, output logic re, output int lat);
        int k;
        lat = -1;
        rd  = '0;
        re  = 1'b0;
        @(negedge CLK);
        CMD_TYPE = t; CMD_LEN = l; CMD_DATA = d; CMD_VALID = 1'b1;
        k = 0;
        while (!CMD_READY && k < 100) begin @(negedge CLK); k++; end
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_DATA  = $urandom;
        CMD_LEN   = LEN_W'($urandom);
        chk("ready_drop", CMD_READY, 0);
        for (int c = 1; c <= 2000; c++) begin
            if (RSP_VALID) begin lat = c; break; end
            @(negedge CLK);
        end
        chk("rsp_timeout", lat >= 0, 1);
        if (lat >= 0) begin
            rd = RSP_DATA;
            re = RSP_ERR;
            chk("ready_at_rsp", CMD_READY, 1);
            @(negedge CLK);
            chk("rsp_one_cycle", RSP_VALID, 0);
        end
    endtask

    // Expected pin streams and response are built straight from the scan rules.
    task automatic run_check(input string tag, input logic [1:0] t, input int n, input logic [31:0] d);
        logic [31:0] rd, er;
        logic        re;
        int          lat, L;
        logic [63:0] s, dd, cpat;
        exp_tms.delete(); exp_tdi.delete();
        mon_tms.delete(); mon_tdi.delete(); mon_t.delete();
        er = '0;
        dd = {32'h0, d};
        case (t)
            CMD_RESET: begin
                exp_tms = '{1, 1, 1, 1, 1, 0};
                exp_tdi = '{0, 0, 0, 0, 0, 0};
            end
            CMD_IDLE: for (int i = 0; i < n; i++) begin exp_tms.push_back(0); exp_tdi.push_back(0); end
            default: begin
                if (t == CMD_IR) begin exp_tms = '{1, 1, 0, 0}; exp_tdi = '{0, 0, 0, 0}; end
                else             begin exp_tms = '{1, 0, 0};    exp_tdi = '{0, 0, 0};    end
                for (int i = 0; i < n; i++) begin
                    exp_tms.push_back(i == n - 1);
                    exp_tdi.push_back(d[i]);
                end
                exp_tms.push_back(1); exp_tms.push_back(0);
                exp_tdi.push_back(0); exp_tdi.push_back(0);
            end
        endcase
        if (t == CMD_IR || t == CMD_DR) begin
            if (t == CMD_IR) begin L = 4; cpat = 64'h1; end
            else begin
                L    = (exp_ir == IDCODE) ? 32 : 1;
                cpat = (L == 32) ? 64'hF0F0F0F0 : 64'h0;
            end
            s = '0;
            for (int j = 0; j < n + ((t == CMD_IR) ? 4 : 0); j++)
                s[j] = (j < L) ? cpat[j] : dd[j-L];
            for (int j = 0; j < n; j++) er[j] = s[j];
            if (t == CMD_IR) exp_ir = s[n +: 4];
        end
        if (t == CMD_RESET) exp_ir = IDCODE;
        do_cmd(t, LEN_W'(n - 1), d, rd, re, lat);
        chk({tag, ":rises"}, mon_tms.size(), exp_tms.size());
        chk({tag, ":tms"},   pack(mon_tms), pack(exp_tms));
        chk({tag, ":tdi"},   pack(mon_tdi), pack(exp_tdi));
        chk({tag, ":data"},  rd, er);
        chk({tag, ":err"},   re, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat, pulses, n;
        logic [31:0] d;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outs", {TCK, TMS, TDI, CMD_READY, RSP_VALID, RSP_ERR, SYNCED}, 7'b0101000);
        chk("reset_data", RSP_DATA, 0);
        RST_N = 1'b1;

        // scan before any RESET is refused without touching TCK
        mon_tms.delete();
        do_cmd(CMD_DR, 5'd7, 32'hA5, rd, re, lat);
        chk("unsync:lat",   lat, 2);
        chk("unsync:err",   re, 1);
        chk("unsync:data",  rd, 0);
        chk("unsync:rises", mon_tms.size(), 0);
        chk("unsync:synced", SYNCED, 0);

        run_check("reset", CMD_RESET, 1, 32'h0);
        chk("reset:period", (mon_t.size() > 1) ? (mon_t[1] - mon_t[0]) : 0, 2 * DIV * T);
        chk("reset:synced", SYNCED, 1);
        chk("reset:tap", tap, RUN_TEST_IDLE);

        run_check("ir_idcode", CMD_IR, 4, 32'h8);
        chk("ir_idcode:tap_ir", ir, 4'b1000);
        run_check("dr_idcode", CMD_DR, 32, 32'h0);
        chk("dr_idcode:value", RSP_DATA, 32'hF0F0F0F0);

        run_check("ir_bypass", CMD_IR, 4, 32'h0);
        run_check("dr_bypass", CMD_DR, 8, 32'hA5);
        chk("dr_bypass:value", RSP_DATA, 32'h4A);
        run_check("dr_n1", CMD_DR, 1, 32'h1);
        run_check("idle_clks", CMD_IDLE, 5, 32'hFFFF_FFFF);
        chk("idle:tap", tap, RUN_TEST_IDLE);

        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0:       d = 32'(IDCODE);
                1:       d = 32'(BYPASS);
                default: d = $urandom_range(0, 15);
            endcase
            run_check("rnd_ir", CMD_IR, 4, d);
            chk("rnd_ir:tap_ir", ir, exp_ir);
            n = $urandom_range(1, 32);
            run_check("rnd_dr", CMD_DR, n, $urandom);
            run_check("rnd_idle", CMD_IDLE, $urandom_range(1, 32), $urandom);
        end

        // abort a DR scan mid-shift with a one-cycle reset
        run_check("ir_idcode2", CMD_IR, 4, 32'h8);
        @(negedge CLK);
        CMD_TYPE = CMD_DR; CMD_LEN = 5'd31; CMD_DATA = $urandom; CMD_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (40) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("abort:outs", {TCK, TMS, CMD_READY, SYNCED, RSP_VALID}, 5'b01100);
        mon_tms.delete();
        pulses = 0;
        repeat (100) begin
            @(negedge CLK);
            if (RSP_VALID) pulses++;
        end
        chk("abort:no_rsp", pulses, 0);
        chk("abort:no_tck", mon_tms.size(), 0);

        run_check("resync", CMD_RESET, 1, 32'h0);
        chk("resync:tap", tap, RUN_TEST_IDLE);
        run_check("dr_after_abort", CMD_DR, 32, $urandom);
        chk("dr_after_abort:value", RSP_DATA, 32'hF0F0F0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
